// File: rtl/shared_pkg.sv
// Types and constants shared by the GLB load path.
package shared_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 64;

    // Destination global-buffer bank for a DRAM-to-GLB transfer.
    typedef enum logic [1:0] {
        IFMAP  = 2'd0,
        FILTER = 2'd1,
        BIAS   = 2'd2
    } data_t;

    // Write controller states.
    typedef enum logic [1:0] {
        GLB_LOAD_IDLE = 2'd0,
        GLB_LOAD_LOAD = 2'd1,
        GLB_LOAD_DONE = 2'd2
    } glb_load_state_t;

    // True for the three encodings that name a real bank.
    function automatic logic is_valid_type(input data_t t);
        logic ok;
        case (t)
            IFMAP, FILTER, BIAS: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/glb_load_ctrl.sv
// Moves cmd_num_words words from the DRAM input FIFO into the selected GLB bank,
// one word per cycle, with a one-cycle registered write stage after each pop.
module glb_load_ctrl
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  data_t                 cmd_type,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_num_words,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  ifmap_wr_en,
    output logic                  filter_wr_en,
    output logic                  bias_wr_en,
    output logic [ADDR_WIDTH-1:0] glb_wr_addr,
    output logic [DATA_WIDTH-1:0] glb_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  type_err,
    output logic [ADDR_WIDTH-1:0] words_done
);

    localparam logic [ADDR_WIDTH-1:0] ONE_W = ADDR_WIDTH'(1);

    glb_load_state_t       state_q,       state_d;
    data_t                 type_q,        type_d;
    logic [ADDR_WIDTH-1:0] base_q,        base_d;
    logic [ADDR_WIDTH-1:0] num_q,         num_d;
    logic [ADDR_WIDTH-1:0] words_done_q,  words_done_d;
    logic                  type_err_q,    type_err_d;
    logic                  ifmap_wr_en_q, ifmap_wr_en_d;
    logic                  filter_wr_en_q, filter_wr_en_d;
    logic                  bias_wr_en_q,  bias_wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,     wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,     wr_data_d;
    logic                  cmd_ready_q,   cmd_ready_d;
    logic                  busy_q,        busy_d;
    logic                  done_q,        done_d;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] next_cnt_s;

    // Next-state, command latch, pop decision and write-stage inputs.
    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        base_d         = base_q;
        num_d          = num_q;
        words_done_d   = words_done_q;
        type_err_d     = type_err_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        ifmap_wr_en_d  = 1'b0;
        filter_wr_en_d = 1'b0;
        bias_wr_en_d   = 1'b0;
        pop_s          = 1'b0;
        next_cnt_s     = words_done_q + ONE_W;

        case (state_q)
            GLB_LOAD_IDLE: begin
                if (cmd_valid) begin
                    type_d       = cmd_type;
                    base_d       = cmd_base_addr;
                    num_d        = cmd_num_words;
                    words_done_d = '0;
                    type_err_d   = !is_valid_type(cmd_type);
                    if (cmd_num_words != '0) begin
                        state_d = GLB_LOAD_LOAD;
                    end else begin
                        state_d = GLB_LOAD_DONE;
                    end
                end else begin
                    state_d = GLB_LOAD_IDLE;
                end
            end
            GLB_LOAD_LOAD: begin
                pop_s = !fifo_empty && (words_done_q < num_q);
                if (pop_s) begin
                    words_done_d = next_cnt_s;
                    // Address wraps naturally at the top of the address space.
                    wr_addr_d    = base_q + words_done_q;
                    wr_data_d    = fifo_dout;
                    // An invalid type drains the FIFO without writing any bank.
                    case (type_q)
                        IFMAP:   ifmap_wr_en_d  = 1'b1;
                        FILTER:  filter_wr_en_d = 1'b1;
                        BIAS:    bias_wr_en_d   = 1'b1;
                        default: ifmap_wr_en_d  = 1'b0;
                    endcase
                    if (next_cnt_s == num_q) begin
                        state_d = GLB_LOAD_DONE;
                    end else begin
                        state_d = GLB_LOAD_LOAD;
                    end
                end else begin
                    state_d = GLB_LOAD_LOAD;
                end
            end
            GLB_LOAD_DONE: begin
                state_d = GLB_LOAD_IDLE;
            end
            default: begin
                state_d = GLB_LOAD_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == GLB_LOAD_IDLE);
        busy_d      = (state_d == GLB_LOAD_LOAD);
        done_d      = (state_d == GLB_LOAD_DONE);
    end

    // State, command registers, write stage and status flags.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q        <= GLB_LOAD_IDLE;
            type_q         <= IFMAP;
            base_q         <= '0;
            num_q          <= '0;
            words_done_q   <= '0;
            type_err_q     <= 1'b0;
            ifmap_wr_en_q  <= 1'b0;
            filter_wr_en_q <= 1'b0;
            bias_wr_en_q   <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            base_q         <= base_d;
            num_q          <= num_d;
            words_done_q   <= words_done_d;
            type_err_q     <= type_err_d;
            ifmap_wr_en_q  <= ifmap_wr_en_d;
            filter_wr_en_q <= filter_wr_en_d;
            bias_wr_en_q   <= bias_wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // The pop strobe is suppressed while reset is held so an abort consumes nothing more.
    assign fifo_rd_en   = pop_s && !reset;
    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign type_err     = type_err_q;
    assign words_done   = words_done_q;
    assign ifmap_wr_en  = ifmap_wr_en_q;
    assign filter_wr_en = filter_wr_en_q;
    assign bias_wr_en   = bias_wr_en_q;
    assign glb_wr_addr  = wr_addr_q;
    assign glb_wr_data  = wr_data_q;

endmodule
